// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] ALIGN_MASK       = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction bus (req/gnt/rvalid) plus the IF/ID-facing instruction outputs.
interface ifu_fetch_if;
    import ifu_fetch_pkg::*;

    logic            ibus_req_o;
    logic [XLEN-1:0] ibus_addr_o;
    logic            ibus_gnt_i;
    logic            ibus_rvalid_i;
    logic [XLEN-1:0] ibus_rdata_i;
    logic [XLEN-1:0] inst_o;
    logic [XLEN-1:0] inst_addr_o;
    logic            inst_valid_o;

    modport master (
        output ibus_req_o, ibus_addr_o, inst_o, inst_addr_o, inst_valid_o,
        input  ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i
    );

    modport slave (
        input  ibus_req_o, ibus_addr_o, inst_o, inst_addr_o, inst_valid_o,
        output ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i
    );

endinterface

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO of fetch entries; push into a full FIFO is legal when popping.
module ifu_fifo
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned  DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues credit-limited in-order fetches, buffers results.
// Optional IFU_ALIGN_CHECK_EN adds a sticky fetch_misalign_o for misaligned jump targets.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_i,
    input  logic [XLEN-1:0]   jump_addr_i,
    input  logic              hold_flag_i,
`ifdef IFU_ALIGN_CHECK_EN
    output logic              fetch_misalign_o,
`endif
    ifu_fetch_if.master       bus
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0]  pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;
    logic             credit_ok;
    logic             misalign;
    logic             req_c;
    logic             accept;
    logic             resp;
    logic             push;
    logic             pop;

    // Entries plus in-flight requests may never exceed the FIFO depth.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign req_c     = rst && credit_ok && !jump_flag_i && !misalign;
    assign accept    = req_c && bus.ibus_gnt_i;
    assign resp      = bus.ibus_rvalid_i && (outstanding != '0);
    assign push      = resp && (discard == '0) && !jump_flag_i;
    assign pop       = !fifo_empty && !hold_flag_i;

    assign outstanding_nxt = outstanding + CNT_W'(accept) - CNT_W'(resp);

    // With no stale responses left, every in-flight request belongs to the current PC stream.
    assign push_entry.addr = pc - (XLEN'(outstanding) << 2);
    assign push_entry.inst = bus.ibus_rdata_i;

    assign bus.ibus_req_o   = req_c;
    assign bus.ibus_addr_o  = pc;
    assign bus.inst_valid_o = !fifo_empty;
    assign bus.inst_o       = fifo_empty ? INST_NOP : fifo_head.inst;
    assign bus.inst_addr_o  = fifo_empty ? '0 : fifo_head.addr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (jump_flag_i) begin
                pc      <= jump_addr_i & ALIGN_MASK;
                discard <= outstanding_nxt;
            end else begin
                if (accept) pc <= pc + 32'd4;
                if (resp && discard != '0) discard <= discard - CNT_W'(1);
            end
        end
    end

`ifdef IFU_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            misalign <= 1'b0;
        end else if (jump_flag_i) begin
            misalign <= (jump_addr_i[1:0] != 2'b00);
        end
    end
    assign fetch_misalign_o = misalign;
`else
    assign misalign = 1'b0;
`endif

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (jump_flag_i),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // A response with nothing in flight is a bus protocol violation; logic drops it.
    rvalid_without_req: assert property (@(posedge clk) disable iff (!rst)
        !(bus.ibus_rvalid_i && outstanding == '0));

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit directly upstream of the IF/ID pipeline register. It owns the PC and issues in-order requests on a req/gnt/rvalid instruction bus.
- Fetched {addr, inst} pairs are buffered in a small prefetch FIFO and presented to IF/ID.
- The block honours the controller's hold and redirect (jump) signals, and discards stale in-flight responses after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- FIFO_DEPTH, 2, prefetch FIFO entries; also the maximum of (entries + outstanding requests). Legal range is 2..8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- jump_flag_i  in  1  redirect request from control.
- jump_addr_i  in  32  redirect target.
- hold_flag_i  in  1  stall from control; the same signal that freezes IF/ID.
- ibus_req_o  out  1  fetch request.
- ibus_addr_o  out  32  fetch address, equal to the PC.
- ibus_gnt_i  in  1  request accepted this cycle.
- ibus_rvalid_i  in  1  response valid; responses arrive in order, at least 1 cycle after gnt.
- ibus_rdata_i  in  32  instruction word.
- inst_o  out  32  instruction to IF/ID.
- inst_addr_o  out  32  address of inst_o.
- inst_valid_o  out  1  inst_o holds a real fetched instruction.

Behaviour:
- Reset (rst==0 at a clk edge):
  - pc=RESET_PC; FIFO empty; outstanding=0; discard=0.
  - ibus_req_o=0, inst_valid_o=0, inst_o=INST_NOP (32'h0000_0013), inst_addr_o=0.
  - Reset wins over every other input, including mid-transaction. Bus responses arriving after reset are ignored, because discard is cleared and the bus is also reset.
- Issue: ibus_req_o=1 whenever (fifo_count + outstanding) < FIFO_DEPTH and no jump is present this cycle. ibus_addr_o=pc.
- Accept: on req & gnt, pc <= pc+4 (wraps mod 2^32) and outstanding++. Without gnt, req and addr stay stable.
- Response: on rvalid:
  - outstanding--.
  - If discard>0, then discard-- and the data is dropped.
  - Otherwise push {addr_of_response, rdata}. Response addresses come from an internal in-order address queue, or equivalently pc minus outstanding*4.
- Output: FIFO head drives inst_o/inst_addr_o/inst_valid_o combinationally. When empty: inst_valid_o=0, inst_o=INST_NOP, inst_addr_o=0.
- Pop: head pops when inst_valid_o & !hold_flag_i. Push and pop in the same cycle are allowed, including into a full FIFO.
- Latency: req+gnt in cycle N and rvalid in N+1 gives inst_valid_o=1 in N+2 (one registered FIFO write).
- Jump (jump_flag_i=1):
  - pc <= {jump_addr_i[31:2],2'b00}; FIFO flushed.
  - discard <= outstanding_after_this_cycle. This count includes a req granted this cycle and excludes a response consumed this cycle.
  - ibus_req_o is forced 0 in the jump cycle. Issue resumes the next cycle from the new pc without waiting for discard==0.
- Priority: rst > jump > hold. A jump while hold_flag_i=1 still flushes. Hold only blocks pop; fetch continues until credits run out.
- Boundaries:
  - FIFO full with outstanding==0 means no req.
  - An rvalid with outstanding==0 is a protocol error; assert in simulation, drop in logic.
  - Counters never wrap; the credit rule guarantees outstanding ≤ FIFO_DEPTH.

Optional Feature:
- Macro: IFU_ALIGN_CHECK_EN.
- Defined:
  - Adds output fetch_misalign_o (1 bit). It is set sticky when a jump has jump_addr_i[1:0]!=0.
  - While set, no requests are issued and the FIFO stays empty.
  - It clears on the next aligned jump or on reset.
- Undefined: port absent; target low bits forced to 00 silently.

Decomposition:
- Shared defines/package:
  - INST_NOP.
  - RESET_PC default.
  - A fetch_entry_t packed struct {addr[31:0], inst[31:0]}.
  - Address-alignment mask constant.
- Natural sub-module: ifu_fifo, a synchronous FIFO of fetch_entry_t.
  - Parameter DEPTH.
  - Ports: push, pop, flush, full, empty, count, head.
  - Same clk/rst convention.

Test Plan:
- Reset release, gnt always 1, rvalid 1 cycle after gnt -> addresses 0,4,8,… issued back-to-back; inst_valid_o first high 2 cycles after the first req; inst_addr_o increments by 4 each unheld cycle.
- hold_flag_i=1 for 5 cycles with FIFO_DEPTH=2 -> at most 2 reqs granted, then ibus_req_o=0; inst_o/inst_addr_o frozen; release -> stream resumes with no lost or duplicated address.
- Jump to 32'h0000_0100 with 2 requests outstanding -> the two late responses are dropped; next inst_addr_o is 0x100, then 0x104.
- Jump coinciding with rvalid and hold -> FIFO empty next cycle, response discarded, first req after jump addresses the target.
- gnt withheld for 3 cycles -> ibus_req_o and ibus_addr_o stable until gnt; pc advances only once.
- rst asserted mid-stream with outstanding>0 -> next cycle all outputs at reset values; first req after release is RESET_PC.
- With IFU_ALIGN_CHECK_EN, jump to 0x102 -> fetch_misalign_o=1 and no req; a later jump to 0x200 clears it.
